i2c_access_arb: RTL and testbench

I2C_ACCESS_ARB -- requirements
Module: i2c_access_arb

---
 rtl/i2c_access_arb.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_access_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_access_arb.sv
// ---------------------------------------------------------------------------
// i2c_access_arb
//
// Shares one I2C master between two requesters (0: register configuration
// engine, 1: touch-point poller). Each requester issues a one-cycle exec
// pulse with its command fields. The command is parked in a pending slot,
// arbitrated round-robin, handed to the master as a one-cycle i2c_exec, and
// answered with a one-cycle done pulse carrying read data and a timeout flag.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_exec/rh_wl/addr/data      requester N command (N = 0, 1)
//   reqN_done/err/rdata            requester N completion, timeout, read data
//   i2c_exec/rh_wl/addr/data       command to the shared I2C master
//   i2c_done/rdata                 master completion and read data
//   busy                           arbiter is not idle
// ---------------------------------------------------------------------------
module i2c_access_arb #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_exec,
    input  logic        req0_rh_wl,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_data,
    input  logic        req1_exec,
    input  logic        req1_rh_wl,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_data,
    output logic        req0_done,
    output logic        req1_done,
    output logic        req0_err,
    output logic        req1_err,
    output logic [7:0]  req0_rdata,
    output logic [7:0]  req1_rdata,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        pend0_q, pend0_d, pend1_q, pend1_d;
    logic        rh0_q, rh0_d, rh1_q, rh1_d;
    logic [15:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [7:0]  data0_q, data0_d, data1_q, data1_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        exec_q, exec_d;
    logic        irh_q, irh_d;
    logic [15:0] iaddr_q, iaddr_d;
    logic [7:0]  idata_q, idata_d;
    logic [7:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        err0_q, err0_d, err1_q, err1_d;

    // Done is decoded straight from RESP so it can never outlive that state.
    assign req0_done  = (state_q == RESP) && !grant_q;
    assign req1_done  = (state_q == RESP) && grant_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign i2c_exec   = exec_q;
    assign i2c_rh_wl  = irh_q;
    assign i2c_addr   = iaddr_q;
    assign i2c_data   = idata_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        pend0_d  = pend0_q;
        pend1_d  = pend1_q;
        rh0_d    = rh0_q;
        rh1_d    = rh1_q;
        addr0_d  = addr0_q;
        addr1_d  = addr1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        exec_d   = 1'b0;
        irh_d    = irh_q;
        iaddr_d  = iaddr_q;
        idata_d  = idata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;

        case (state_q)
            IDLE: begin
                if (pend0_q || pend1_q) begin
                    // On a tie the requester not served last wins.
                    grant_d = (pend0_q && pend1_q) ? ~last_q : pend1_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                exec_d  = 1'b1;
                irh_d   = grant_q ? rh1_q   : rh0_q;
                iaddr_d = grant_q ? addr1_q : addr0_q;
                idata_d = grant_q ? data1_q : data0_q;
                cnt_d   = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (i2c_done) begin
                    if (grant_q) begin
                        rdata1_d = i2c_rdata;
                        err1_d   = 1'b0;
                    end else begin
                        rdata0_d = i2c_rdata;
                        err0_d   = 1'b0;
                    end
                    state_d = RESP;
                end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                    if (grant_q) begin
                        rdata1_d = 8'h00;
                        err1_d   = 1'b1;
                    end else begin
                        rdata0_d = 8'h00;
                        err0_d   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (grant_q) pend1_d = 1'b0;
                else         pend0_d = 1'b0;
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new request is taken when the slot is free, or when the slot is
        // being released this very cycle; the set overrides the clear above.
        if (req0_exec && (!pend0_q || req0_done)) begin
            pend0_d = 1'b1;
            rh0_d   = req0_rh_wl;
            addr0_d = req0_addr;
            data0_d = req0_data;
        end
        if (req1_exec && (!pend1_q || req1_done)) begin
            pend1_d = 1'b1;
            rh1_d   = req1_rh_wl;
            addr1_d = req1_addr;
            data1_d = req1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend0_q  <= 1'b0;
            pend1_q  <= 1'b0;
            rh0_q    <= 1'b0;
            rh1_q    <= 1'b0;
            addr0_q  <= 16'd0;
            addr1_q  <= 16'd0;
            data0_q  <= 8'd0;
            data1_q  <= 8'd0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 16'd0;
            exec_q   <= 1'b0;
            irh_q    <= 1'b0;
            iaddr_q  <= 16'd0;
            idata_q  <= 8'd0;
            rdata0_q <= 8'd0;
            rdata1_q <= 8'd0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend0_q  <= pend0_d;
            pend1_q  <= pend1_d;
            rh0_q    <= rh0_d;
            rh1_q    <= rh1_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            exec_q   <= exec_d;
            irh_q    <= irh_d;
            iaddr_q  <= iaddr_d;
            idata_q  <= idata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

endmodule

// File: tb/tb_i2c_access_arb.sv
// ---------------------------------------------------------------------------
// tb_i2c_access_arb
//
// Bench for i2c_access_arb with TIMEOUT_CYC = 20. An always-on master model
// answers every i2c_exec after a programmable (or random) delay. Directed
// single-transaction vectors come from a table; arbitration, dropping and
// reset are hand-written sequences; a random phase is compared every cycle
// against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_i2c_access_arb;

    localparam logic [15:0] TO = 16'd20;

    logic        clk;
    logic        rst_n;
    logic        req0_exec, req0_rh_wl, req1_exec, req1_rh_wl;
    logic [15:0] req0_addr, req1_addr;
    logic [7:0]  req0_data, req1_data;
    logic        req0_done, req1_done, req0_err, req1_err;
    logic [7:0]  req0_rdata, req1_rdata;
    logic        i2c_exec, i2c_rh_wl, i2c_done, busy;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data, i2c_rdata;

    i2c_access_arb #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_exec(req0_exec), .req0_rh_wl(req0_rh_wl), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_exec(req1_exec), .req1_rh_wl(req1_rh_wl), .req1_addr(req1_addr), .req1_data(req1_data),
        .req0_done(req0_done), .req1_done(req1_done), .req0_err(req0_err), .req1_err(req1_err),
        .req0_rdata(req0_rdata), .req1_rdata(req1_rdata),
        .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
        .i2c_done(i2c_done), .i2c_rdata(i2c_rdata), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- master model ----------------
    int         mst_delay = -1;   // -1 random 1..21, 0 never answer, else fixed
    logic [7:0] mst_rdata = 8'h00;
    int         done_at = -1;
    int         last_d = 0;
    logic [7:0] done_rdata = 8'h00;

    initial begin
        i2c_done  = 1'b0;
        i2c_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (done_at >= 0 && cyc == done_at) begin
                i2c_done  = 1'b1;
                i2c_rdata = done_rdata;
            end else begin
                i2c_done  = 1'b0;
                i2c_rdata = 8'($urandom);
            end
        end
    end

    // ---------------- reference model ----------------
    bit         model_en = 1'b0;
    logic       m_pend[2];
    logic       m_rh[2];
    logic [15:0] m_addr[2];
    logic [7:0] m_data[2];
    logic [7:0] m_rd[2];
    logic       m_er[2];
    logic       m_free, m_last, m_g, m_xe;
    logic [7:0] m_xr;
    int         m_gcyc, m_rcyc;

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_pend[n] = 1'b0; m_rh[n] = 1'b0; m_addr[n] = 16'h0; m_data[n] = 8'h0;
            m_rd[n] = 8'h00; m_er[n] = 1'b0;
        end
        m_free = 1'b1; m_last = 1'b1; m_g = 1'b0;
        m_gcyc = -10; m_rcyc = -1; m_xr = 8'h00; m_xe = 1'b0;
    endtask

    task automatic model_step();
        logic        ed[2], dn[2], ex[2], rh[2];
        logic [15:0] ad[2];
        logic [7:0]  da[2], rdo[2];
        logic        ero[2];
        logic        exp_exec;
        dn[0] = req0_done;  dn[1] = req1_done;
        ex[0] = req0_exec;  ex[1] = req1_exec;
        rh[0] = req0_rh_wl; rh[1] = req1_rh_wl;
        ad[0] = req0_addr;  ad[1] = req1_addr;
        da[0] = req0_data;  da[1] = req1_data;
        rdo[0] = req0_rdata; rdo[1] = req1_rdata;
        ero[0] = req0_err;  ero[1] = req1_err;

        chk("rnd busy", busy, !m_free);
        if (m_free && (m_pend[0] || m_pend[1])) begin
            m_g    = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
            m_gcyc = cyc;
            m_free = 1'b0;
            m_rcyc = -1;
        end
        exp_exec = !m_free && (cyc == m_gcyc + 2);
        chk("rnd i2c_exec", i2c_exec, exp_exec);
        if (exp_exec) begin
            chk("rnd i2c_addr", i2c_addr, m_addr[m_g]);
            chk("rnd i2c_data", i2c_data, m_data[m_g]);
            chk("rnd i2c_rh_wl", i2c_rh_wl, m_rh[m_g]);
            if (last_d >= 1 && last_d <= int'(TO) - 1) begin
                m_rcyc = cyc + last_d + 1; m_xr = done_rdata; m_xe = 1'b0;
            end else begin
                m_rcyc = cyc + int'(TO); m_xr = 8'h00; m_xe = 1'b1;
            end
        end
        for (int n = 0; n < 2; n++) begin
            ed[n] = !m_free && (cyc == m_rcyc) && (m_g == 1'(n));
            chk(n == 0 ? "rnd req0_done" : "rnd req1_done", dn[n], ed[n]);
            if (ed[n]) begin
                m_rd[n] = m_xr;
                m_er[n] = m_xe;
            end
            chk(n == 0 ? "rnd req0_rdata" : "rnd req1_rdata", rdo[n], m_rd[n]);
            chk(n == 0 ? "rnd req0_err" : "rnd req1_err", ero[n], m_er[n]);
        end
        for (int n = 0; n < 2; n++) begin
            logic acc;
            acc = ex[n] && (!m_pend[n] || ed[n]);
            if (ed[n]) m_pend[n] = 1'b0;
            if (acc) begin
                m_pend[n] = 1'b1; m_rh[n] = rh[n]; m_addr[n] = ad[n]; m_data[n] = da[n];
            end
        end
        if (ed[0] || ed[1]) begin
            m_last = m_g;
            m_free = 1'b1;
        end
    endtask

    // Master scheduling and model share one process so their order is fixed.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_at = -1;
            end else begin
                if (i2c_exec) begin
                    d = (mst_delay >= 0) ? mst_delay : int'($urandom_range(21, 1));
                    done_at    = (d > 0) ? cyc + d : -1;
                    done_rdata = (mst_delay >= 0) ? mst_rdata : 8'($urandom);
                    last_d     = d;
                end
                if (model_en) model_step();
            end
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        bit          req;
        bit          rh;
        logic [15:0] addr;
        logic [7:0]  data;
        int          delay;
        logic [7:0]  rin;
        int          lat;
        bit          err;
        logic [7:0]  rdata;
    } vec_t;

    logic [15:0] addr_q[$];
    logic [7:0]  data_q[$];
    int          done_q[$];

    task automatic observe(input int n);
        addr_q.delete(); data_q.delete(); done_q.delete();
        repeat (n) begin
            @(negedge clk);
            if (i2c_exec) begin
                addr_q.push_back(i2c_addr);
                data_q.push_back(i2c_data);
            end
            if (req0_done) done_q.push_back(0);
            if (req1_done) done_q.push_back(1);
        end
    endtask

    task automatic pulse(input bit p0, input bit p1, input logic [15:0] a0, input logic [7:0] d0,
                         input logic [15:0] a1, input logic [7:0] d1);
        @(posedge clk); #1;
        req0_exec = p0; req0_rh_wl = 1'b0; req0_addr = a0; req0_data = d0;
        req1_exec = p1; req1_rh_wl = 1'b1; req1_addr = a1; req1_data = d1;
        @(posedge clk); #1;
        req0_exec = 1'b0; req1_exec = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int c0, e_cyc, d_cyc, n_exec, n_done, n_other;
        logic [15:0] g_addr;
        logic [7:0]  g_data, g_rd;
        logic        g_rh, g_err, busy_after;
        g_addr = 16'hx; g_data = 8'hx; g_rd = 8'hx; g_rh = 1'bx; g_err = 1'bx;
        mst_delay = v.delay;
        mst_rdata = v.rin;
        @(posedge clk); #1;
        if (v.req) begin
            req1_exec = 1'b1; req1_rh_wl = v.rh; req1_addr = v.addr; req1_data = v.data;
        end else begin
            req0_exec = 1'b1; req0_rh_wl = v.rh; req0_addr = v.addr; req0_data = v.data;
        end
        c0 = cyc;
        @(posedge clk); #1;
        req0_exec = 1'b0; req1_exec = 1'b0;
        e_cyc = -1; d_cyc = -1; n_exec = 0; n_done = 0; n_other = 0; busy_after = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (i2c_exec) begin
                n_exec++;
                if (e_cyc < 0) begin
                    e_cyc = cyc; g_addr = i2c_addr; g_data = i2c_data; g_rh = i2c_rh_wl;
                end
            end
            if (d_cyc >= 0 && cyc == d_cyc + 1) busy_after = busy;
            if (v.req ? req1_done : req0_done) begin
                n_done++;
                if (d_cyc < 0) begin
                    d_cyc = cyc;
                    g_rd  = v.req ? req1_rdata : req0_rdata;
                    g_err = v.req ? req1_err : req0_err;
                end
            end
            if (v.req ? req0_done : req1_done) n_other++;
        end
        chk("vec exec latency", e_cyc - c0, 3);
        chk("vec exec count", n_exec, 1);
        chk("vec i2c_addr", g_addr, v.addr);
        chk("vec i2c_data", g_data, v.data);
        chk("vec i2c_rh_wl", g_rh, v.rh);
        chk("vec done count", n_done, 1);
        chk("vec done latency", d_cyc - e_cyc, v.lat);
        chk("vec err", g_err, v.err);
        chk("vec rdata", g_rd, v.rdata);
        chk("vec other done", n_other, 0);
        chk("vec busy after done", busy_after, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[6];

    initial begin
        vec_t rv;
        vecs[0] = '{1'b0, 1'b0, 16'h8047, 8'h5A, 10, 8'h33, 11, 1'b0, 8'h33};
        vecs[1] = '{1'b1, 1'b1, 16'h814E, 8'h00,  4, 8'h81,  5, 1'b0, 8'h81};
        vecs[2] = '{1'b0, 1'b1, 16'h0001, 8'h00,  0, 8'hEE, 20, 1'b1, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 8'hFF, 19, 8'hC3, 20, 1'b0, 8'hC3};
        vecs[4] = '{1'b0, 1'b1, 16'h1234, 8'hAA, 20, 8'h77, 20, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 16'h00FF, 8'h00,  1, 8'h5E,  2, 1'b0, 8'h5E};

        rst_n = 1'b0;
        req0_exec = 1'b0; req0_rh_wl = 1'b0; req0_addr = 16'h0; req0_data = 8'h0;
        req1_exec = 1'b0; req1_rh_wl = 1'b0; req1_addr = 16'h0; req1_data = 8'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset i2c side", {i2c_exec, i2c_rh_wl, i2c_addr, i2c_data, busy}, 32'h0);
        chk("reset req side", {req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single transactions from the table
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // round-robin: first tie goes to 0, then a tie after 0 was served goes to 1
        mst_delay = 3; mst_rdata = 8'h11;
        pulse(1'b1, 1'b1, 16'hA000, 8'h01, 16'hB001, 8'h02);
        observe(40);
        chk("tie1 exec count", addr_q.size(), 2);
        chk("tie1 first grant", addr_q[0], 16'hA000);
        chk("tie1 second grant", addr_q[1], 16'hB001);
        chk("tie1 first done", done_q[0], 0);
        chk("tie1 second done", done_q[1], 1);
        pulse(1'b1, 1'b0, 16'hC002, 8'h03, 16'h0, 8'h0);
        observe(20);
        chk("solo0 done", done_q.size(), 1);
        pulse(1'b1, 1'b1, 16'hD003, 8'h04, 16'hE004, 8'h05);
        observe(40);
        chk("tie2 exec count", addr_q.size(), 2);
        chk("tie2 first grant", addr_q[0], 16'hE004);
        chk("tie2 second grant", addr_q[1], 16'hD003);

        // second exec while pending is dropped
        mst_delay = 5;
        @(posedge clk); #1;
        req0_exec = 1'b1; req0_rh_wl = 1'b0; req0_addr = 16'h1111; req0_data = 8'h22;
        @(posedge clk); #1;
        req0_addr = 16'h3333; req0_data = 8'h44;
        @(posedge clk); #1;
        req0_exec = 1'b0;
        observe(30);
        chk("drop exec count", addr_q.size(), 1);
        chk("drop addr", addr_q[0], 16'h1111);
        chk("drop data", data_q[0], 8'h22);
        chk("drop done count", done_q.size(), 1);

        // random phase against the reference model
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        mst_delay = -1;
        rst_n = 1'b1;
        model_en = 1'b1;
        repeat (600) begin
            @(posedge clk); #1;
            req0_exec = ($urandom_range(3, 0) == 0); req0_rh_wl = 1'($urandom);
            req0_addr = 16'($urandom); req0_data = 8'($urandom);
            req1_exec = ($urandom_range(3, 0) == 0); req1_rh_wl = 1'($urandom);
            req1_addr = 16'($urandom); req1_data = 8'($urandom);
        end
        @(posedge clk); #1;
        req0_exec = 1'b0; req1_exec = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        model_en = 1'b0;
        chk("rnd drained", {m_free, m_pend[0], m_pend[1]}, 3'b100);

        // reset in WAIT abandons the transaction
        mst_delay = 0;
        @(posedge clk); #1;
        req0_exec = 1'b1; req0_rh_wl = 1'b1; req0_addr = 16'h2222; req0_data = 8'h66;
        @(posedge clk); #1;
        req0_exec = 1'b0;
        observe(8);
        chk("prewait exec seen", addr_q.size(), 1);
        chk("prewait busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset i2c side", {i2c_exec, i2c_rh_wl, i2c_addr, i2c_data, busy}, 32'h0);
        chk("midreset req side", {req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata}, 32'h0);
        observe(3);
        chk("midreset no done", done_q.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        observe(4);
        chk("postreset no done", done_q.size(), 0);
        rv = '{1'b1, 1'b1, 16'h814E, 8'h00, 6, 8'h9C, 7, 1'b0, 8'h9C};
        run_vec(rv);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
